// File: rtl/vend_fsm.sv
// Vending-machine control FSM: collects coins into credit, dispenses one item
// at a fixed price, and returns change or refunds on cancel.
module vend_fsm #(
  parameter int unsigned PRICE       = 65,
  parameter int unsigned MAX_CREDIT  = 200,
  parameter int unsigned DISP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       select,
  input  logic       cancel,
  output logic [2:0] state,
  output logic [7:0] credit,
  output logic       dispense,
  output logic       change_valid,
  output logic [7:0] change,
  output logic       coin_reject
);

  localparam int unsigned CRED_W = 8;
  localparam int unsigned SUM_W  = CRED_W + 1;
  localparam int unsigned CNT_W  = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_COLLECT  = 3'b001,
    S_DISPENSE = 3'b010,
    S_CHANGE   = 3'b011,
    S_REFUND   = 3'b100
  } state_e;

  state_e            state_q, state_d;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic [CRED_W-1:0] change_q, change_d;
  logic              dispense_q, dispense_d;
  logic              change_valid_q, change_valid_d;
  logic              coin_reject_q, coin_reject_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [CRED_W-1:0] coin_val;
  logic [CRED_W-1:0] credit_base;
  logic [SUM_W-1:0]  coin_sum;
  logic              coin_present;
  logic              coin_fits;
  logic [CRED_W-1:0] remain;

  // Coin decode and ceiling check; IDLE always starts a fresh credit from zero
  always_comb begin
    coin_val = '0;
    case (coin_type)
      2'b01:   coin_val = CRED_W'(5);
      2'b10:   coin_val = CRED_W'(10);
      2'b11:   coin_val = CRED_W'(25);
      default: coin_val = '0;
    endcase
    coin_present = coin_valid && (coin_type != 2'b00);
    credit_base  = (state_q == S_IDLE) ? '0 : credit_q;
    coin_sum     = {1'b0, credit_base} + {1'b0, coin_val};
    coin_fits    = coin_sum <= SUM_W'(MAX_CREDIT);
    remain       = credit_q - CRED_W'(PRICE);
  end

  // Next-state and registered-output logic; a present coin is rejected unless accepted
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    change_d       = change_q;
    cnt_d          = cnt_q;
    dispense_d     = 1'b0;
    change_valid_d = 1'b0;
    coin_reject_d  = coin_present;

    case (state_q)
      S_IDLE: begin
        if (coin_present && coin_fits) begin
          credit_d      = coin_sum[CRED_W-1:0];
          coin_reject_d = 1'b0;
          state_d       = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          state_d        = S_REFUND;
          change_valid_d = 1'b1;
          change_d       = credit_q;
        end else if (select && (credit_q >= CRED_W'(PRICE))) begin
          state_d    = S_DISPENSE;
          dispense_d = 1'b1;
          cnt_d      = '0;
        end else if (coin_present && coin_fits) begin
          credit_d      = coin_sum[CRED_W-1:0];
          coin_reject_d = 1'b0;
        end
      end
      S_DISPENSE: begin
        if (cnt_q == CNT_W'(DISP_CYCLES - 1)) begin
          credit_d = remain;
          if (remain != '0) begin
            state_d        = S_CHANGE;
            change_valid_d = 1'b1;
            change_d       = remain;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          dispense_d = 1'b1;
        end
      end
      S_CHANGE, S_REFUND: begin
        credit_d = '0;
        state_d  = S_IDLE;
      end
      default: begin
        credit_d = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      change_q       <= '0;
      cnt_q          <= '0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_q       <= change_d;
      cnt_q          <= cnt_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
    end
  end

  assign state        = state_q;
  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign change_valid = change_valid_q;
  assign change       = change_q;
  assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_vend_fsm.sv
// Directed bench for vend_fsm: exact purchase, purchase with change, cancel,
// credit ceiling, rejects during dispense, priority collisions and async reset.
module tb_vend_fsm;

  logic       clk;
  logic       reset;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       select;
  logic       cancel;
  logic [2:0] state;
  logic [7:0] credit;
  logic       dispense;
  logic       change_valid;
  logic [7:0] change;
  logic       coin_reject;

  int checks = 0;
  int errors = 0;

  vend_fsm #(.PRICE(65), .MAX_CREDIT(200), .DISP_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .select       (select),
    .cancel       (cancel),
    .state        (state),
    .credit       (credit),
    .dispense     (dispense),
    .change_valid (change_valid),
    .change       (change),
    .coin_reject  (coin_reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    tick();
    coin_valid = 1'b0;
    coin_type  = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b0; coin_valid = 1'b0; coin_type = 2'b00; select = 1'b0; cancel = 1'b0;
    tick(); tick();
    checks++; if (state !== 3'b000) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (credit !== 8'd0) begin errors++; $display("FAIL reset_credit got %0d exp 0", credit); end
    checks++; if ({dispense, change_valid, coin_reject} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b exp 000", {dispense, change_valid, coin_reject}); end
    checks++; if (change !== 8'd0) begin errors++; $display("FAIL reset_change got %0d exp 0", change); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_exact_price();
    coin(2'b11);
    checks++; if (credit !== 8'd25 || state !== 3'b001) begin errors++; $display("FAIL exact_q1 got credit %0d state %0d exp 25/1", credit, state); end
    coin(2'b11);
    checks++; if (credit !== 8'd50) begin errors++; $display("FAIL exact_q2 got %0d exp 50", credit); end
    coin(2'b10);
    checks++; if (credit !== 8'd60) begin errors++; $display("FAIL exact_dime got %0d exp 60", credit); end
    coin(2'b01);
    checks++; if (credit !== 8'd65) begin errors++; $display("FAIL exact_nickel got %0d exp 65", credit); end
    select = 1'b1; tick(); select = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (state !== 3'b010 || dispense !== 1'b1) begin errors++; $display("FAIL exact_disp%0d got state %0d dispense %b exp 2/1", i, state, dispense); end
      tick();
    end
    checks++; if (state !== 3'b000 || dispense !== 1'b0 || change_valid !== 1'b0) begin errors++; $display("FAIL exact_end got state %0d disp %b cv %b exp 0/0/0", state, dispense, change_valid); end
    checks++; if (credit !== 8'd0) begin errors++; $display("FAIL exact_credit0 got %0d exp 0", credit); end
  endtask

  task automatic test_change();
    coin(2'b11); coin(2'b11); coin(2'b11);
    checks++; if (credit !== 8'd75) begin errors++; $display("FAIL chg_credit got %0d exp 75", credit); end
    select = 1'b1; tick(); select = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (dispense !== 1'b1) begin errors++; $display("FAIL chg_disp%0d got %b exp 1", i, dispense); end
      tick();
    end
    checks++; if (state !== 3'b011 || change_valid !== 1'b1 || change !== 8'd10) begin errors++; $display("FAIL chg_out got state %0d cv %b change %0d exp 3/1/10", state, change_valid, change); end
    checks++; if (dispense !== 1'b0) begin errors++; $display("FAIL chg_disp_off got %b exp 0", dispense); end
    tick();
    checks++; if (state !== 3'b000 || credit !== 8'd0 || change_valid !== 1'b0) begin errors++; $display("FAIL chg_idle got state %0d credit %0d cv %b exp 0/0/0", state, credit, change_valid); end
    checks++; if (change !== 8'd10) begin errors++; $display("FAIL chg_hold got %0d exp 10", change); end
  endtask

  task automatic test_cancel();
    coin(2'b10);
    select = 1'b1; tick(); select = 1'b0;
    checks++; if (state !== 3'b001 || dispense !== 1'b0 || credit !== 8'd10) begin errors++; $display("FAIL cancel_sel_ignored got state %0d disp %b credit %0d exp 1/0/10", state, dispense, credit); end
    cancel = 1'b1; tick(); cancel = 1'b0;
    checks++; if (state !== 3'b100 || change_valid !== 1'b1 || change !== 8'd10) begin errors++; $display("FAIL cancel_refund got state %0d cv %b change %0d exp 4/1/10", state, change_valid, change); end
    tick();
    checks++; if (state !== 3'b000 || credit !== 8'd0 || change_valid !== 1'b0) begin errors++; $display("FAIL cancel_idle got state %0d credit %0d cv %b exp 0/0/0", state, credit, change_valid); end
  endtask

  task automatic test_ceiling();
    for (int i = 0; i < 8; i++) coin(2'b11);
    checks++; if (credit !== 8'd200) begin errors++; $display("FAIL ceil_credit got %0d exp 200", credit); end
    coin(2'b01);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd200) begin errors++; $display("FAIL ceil_reject got rej %b credit %0d exp 1/200", coin_reject, credit); end
    tick();
    checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL ceil_reject_pulse got %b exp 0", coin_reject); end
    coin(2'b00);
    checks++; if (coin_reject !== 1'b0 || credit !== 8'd200) begin errors++; $display("FAIL ceil_type0 got rej %b credit %0d exp 0/200", coin_reject, credit); end
    select = 1'b1; tick(); select = 1'b0;
    tick(); tick(); tick(); tick();
    checks++; if (state !== 3'b011 || change_valid !== 1'b1 || change !== 8'd135) begin errors++; $display("FAIL ceil_change got state %0d cv %b change %0d exp 3/1/135", state, change_valid, change); end
    tick();
  endtask

  task automatic test_collisions();
    coin(2'b11); coin(2'b11); coin(2'b11);
    select = 1'b1; tick(); select = 1'b0;
    coin(2'b11);
    checks++; if (coin_reject !== 1'b1 || state !== 3'b010 || credit !== 8'd75) begin errors++; $display("FAIL coll_disp_coin got rej %b state %0d credit %0d exp 1/2/75", coin_reject, state, credit); end
    tick(); tick(); tick();
    checks++; if (state !== 3'b011 || change !== 8'd10) begin errors++; $display("FAIL coll_disp_change got state %0d change %0d exp 3/10", state, change); end
    tick();
    coin(2'b11); coin(2'b11); coin(2'b10); coin(2'b10);
    checks++; if (credit !== 8'd70) begin errors++; $display("FAIL coll_credit got %0d exp 70", credit); end
    cancel = 1'b1; select = 1'b1; coin_valid = 1'b1; coin_type = 2'b11;
    tick();
    cancel = 1'b0; select = 1'b0; coin_valid = 1'b0; coin_type = 2'b00;
    checks++; if (state !== 3'b100 || change_valid !== 1'b1 || change !== 8'd70) begin errors++; $display("FAIL coll_refund got state %0d cv %b change %0d exp 4/1/70", state, change_valid, change); end
    checks++; if (coin_reject !== 1'b1 || dispense !== 1'b0) begin errors++; $display("FAIL coll_reject got rej %b disp %b exp 1/0", coin_reject, dispense); end
    tick();
    checks++; if (state !== 3'b000 || credit !== 8'd0) begin errors++; $display("FAIL coll_idle got state %0d credit %0d exp 0/0", state, credit); end
  endtask

  task automatic test_held_select();
    coin(2'b11); coin(2'b11); coin(2'b11);
    select = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    checks++; if (state !== 3'b000 || dispense !== 1'b0) begin errors++; $display("FAIL held_idle got state %0d disp %b exp 0/0", state, dispense); end
    tick();
    checks++; if (state !== 3'b000 || dispense !== 1'b0) begin errors++; $display("FAIL held_no_revend got state %0d disp %b exp 0/0", state, dispense); end
    select = 1'b0;
  endtask

  task automatic test_async_reset();
    coin(2'b11); coin(2'b11); coin(2'b11);
    select = 1'b1; tick(); select = 1'b0;
    tick();
    checks++; if (state !== 3'b010 || dispense !== 1'b1) begin errors++; $display("FAIL areset_pre got state %0d disp %b exp 2/1", state, dispense); end
    #2 reset = 1'b0;
    #1;
    checks++; if (state !== 3'b000 || credit !== 8'd0 || change !== 8'd0) begin errors++; $display("FAIL areset_vals got state %0d credit %0d change %0d exp 0/0/0", state, credit, change); end
    checks++; if ({dispense, change_valid, coin_reject} !== 3'b000) begin errors++; $display("FAIL areset_strobes got %b exp 000", {dispense, change_valid, coin_reject}); end
    reset = 1'b1;
    coin(2'b01);
    checks++; if (credit !== 8'd5 || state !== 3'b001) begin errors++; $display("FAIL areset_nickel got credit %0d state %0d exp 5/1", credit, state); end
    checks++; if (change_valid !== 1'b0) begin errors++; $display("FAIL areset_no_change got %b exp 0", change_valid); end
  endtask

  initial begin
    test_reset();
    test_exact_price();
    test_change();
    test_cancel();
    test_ceiling();
    test_collisions();
    test_held_select();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_fsm.md
# vend_fsm

Vending-machine control FSM that accepts coins, accumulates credit, dispenses one item at a fixed price and returns change. It sits directly upstream of the idle-cycle counter: its `state` output drives that counter's 3-bit `state` input, and `state == 3'b000` means IDLE. All outputs are registered.

## Interface
- `PRICE`, default 65: item price in cents; must be 5..MAX_CREDIT and a multiple of 5.
- `MAX_CREDIT`, default 200: credit ceiling in cents; must be at most 255.
- `DISP_CYCLES`, default 4: number of cycles `dispense` is held high; must be at least 1.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `coin_valid`  input  1  single-cycle coin strobe.
- `coin_type`  input  2  coin value, qualified by `coin_valid`: 00 = 0 (ignored), 01 = 5, 10 = 10, 11 = 25.
- `select`  input  1  purchase request (level sampled each cycle).
- `cancel`  input  1  refund request (level sampled each cycle).
- `state`  output  3  FSM state encoding, to the downstream counter.
- `credit`  output  8  current credit in cents.
- `dispense`  output  1  item release.
- `change_valid`  output  1  single-cycle strobe; `change` is valid while it is high.
- `change`  output  8  amount to return in cents.
- `coin_reject`  output  1  single-cycle strobe; the coin was not accepted.

## Operation
- State encodings:
  - IDLE = 000
  - COLLECT = 001
  - DISPENSE = 010
  - CHANGE = 011
  - REFUND = 100
  - Codes 101–111 are illegal and go to IDLE on the next edge, with `credit` cleared.
- Reset values: `state` = 000, `credit` = 0, `change` = 0, and `dispense`, `change_valid`, `coin_reject` all 0. The dispense counter is also cleared.
- IDLE:
  - An accepted coin sets `credit` to the coin value and moves to COLLECT.
  - `select` and `cancel` are ignored.
- COLLECT, evaluated each cycle in priority order `cancel` > `select` > coin:
  - `cancel`: go to REFUND.
  - `select` with `credit` >= PRICE: go to DISPENSE.
  - `select` with `credit` < PRICE: ignored; stay in COLLECT.
  - Coin accepted: add its value to `credit`.
  - If `cancel` or `select` wins while a coin arrives in the same cycle, that coin is rejected.
- Coin acceptance:
  - A coin is accepted only in IDLE or COLLECT, and only if `credit` + value <= MAX_CREDIT.
  - Otherwise `coin_reject` = 1 on the next cycle and `credit` is unchanged.
  - `coin_type` = 00 with `coin_valid` is ignored; it is neither accepted nor rejected.
- DISPENSE:
  - `dispense` = 1 for exactly DISP_CYCLES cycles.
  - On the last cycle, `credit` is reduced by PRICE.
  - Next state is CHANGE if the remaining credit is > 0, else IDLE.
  - Every coin received is rejected; `select` and `cancel` are ignored.
- CHANGE: one cycle with `change_valid` = 1 and `change` = remaining credit. `credit` goes to 0 and the FSM returns to IDLE.
- REFUND: one cycle with `change_valid` = 1 and `change` = `credit`. `credit` goes to 0 and the FSM returns to IDLE.
- Arithmetic: 9-bit sum for the ceiling compare, result truncated to 8 bits. `credit` can never exceed MAX_CREDIT or go below 0.
- `change` holds its last value when `change_valid` = 0.

## Timing
- Coin strobe in cycle N: `credit` or `coin_reject` updates at the edge ending cycle N, so it is visible in cycle N+1.
- `select` accepted in cycle N:
  - `state` = DISPENSE and `dispense` = 1 in cycles N+1 .. N+DISP_CYCLES.
  - CHANGE (if any) in cycle N+DISP_CYCLES+1.
  - IDLE in the cycle after that, or in cycle N+DISP_CYCLES+1 if there is no change.
- `cancel` in cycle N: REFUND with `change_valid` = 1 in cycle N+1, IDLE in cycle N+2.
- Held `select`/`cancel` levels have no effect outside COLLECT, so holding them causes no double vend.
- Reset asserted mid-operation (any state) clears everything immediately. Credit is lost and no change is issued.
- Deassertion of reset is synchronous to `clk` externally. The first active edge after release evaluates inputs from IDLE.

## Test plan
1. Reset, then quarter, quarter, dime, nickel, then `select`:
   - `credit` steps 25 → 50 → 60 → 65.
   - `dispense` high for 4 cycles.
   - No CHANGE state; `state` returns to 000.
2. Three quarters, then `select`:
   - `dispense` for 4 cycles.
   - Then `change_valid` = 1 with `change` = 10.
   - Then IDLE with `credit` = 0.
3. Dime, then `select` → ignored, `state` stays 001. Then `cancel` → `change_valid` with `change` = 10, then IDLE.
4. Eight quarters (`credit` = 200), then a nickel:
   - `coin_reject` = 1 for one cycle, `credit` stays 200.
   - `select` then gives `change` = 135.
5. Quarter while in DISPENSE → `coin_reject`. Same-cycle `cancel` + `select` + coin in COLLECT with `credit` = 70 → REFUND with `change` = 70, `coin_reject` = 1.
6. Assert `reset` during DISPENSE cycle 2:
   - All outputs 0 asynchronously and `state` = 000.
   - After release, a nickel gives `credit` = 5.
